cronometro_ctrl: RTL and testbench

Front-panel controller for the stopwatch datapath. It debounces three raw board buttons and runs a four-state FSM (IDLE / RUN / PAUSE / LAP). It drives the datapath's `running` and clear inputs, and holds a lap (split) capture register. It also selects whether the display path shows live digits or the frozen lap value. It sits between the KEY inputs and the stopwatch counter, and between the counter's BCD outputs and the 7-segment decoders.

---
 rtl/cronometro_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cronometro_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cronometro_ctrl.sv
// Stopwatch front-panel controller: debounces start/lap/clear buttons, runs the
// IDLE/RUN/PAUSE/LAP sequencer, and holds the lap (split) capture for the display.

module cronometro_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, then count consecutive samples that disagree with
    // the accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_p1;
                press <= ~sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module cronometro_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LAP_MAX         = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_start_n,
    input  logic        key_lap_n,
    input  logic        key_clear_n,
    input  logic [31:0] live_digits,
    output logic        running,
    output logic        clear,
    output logic [31:0] disp_digits,
    output logic        lap_active,
    output logic [3:0]  lap_count,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [3:0] LAP_SAT = 4'(LAP_MAX);

    logic ev_start;
    logic ev_lap;
    logic ev_clear;

    state_t      cur;
    state_t      nxt;
    logic [31:0] lap_reg;
    logic [31:0] nxt_lap_reg;
    logic [3:0]  nxt_lap_count;
    logic        nxt_clear;
    logic        nxt_running;
    logic        nxt_lap_active;
    logic [31:0] nxt_disp;

    cronometro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .key_n (key_start_n),
        .press (ev_start)
    );

    cronometro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .key_n (key_lap_n),
        .press (ev_lap)
    );

    cronometro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .key_n (key_clear_n),
        .press (ev_clear)
    );

    // Only the highest-priority event is considered; a lower one arriving in the
    // same cycle is dropped even when the winner has no effect in this state.
    always_comb begin
        nxt           = cur;
        nxt_clear     = 1'b0;
        nxt_lap_reg   = lap_reg;
        nxt_lap_count = lap_count;
        if (ev_clear) begin
            case (cur)
                IDLE:  nxt_clear = 1'b1;
                PAUSE: begin
                    nxt           = IDLE;
                    nxt_clear     = 1'b1;
                    nxt_lap_count = '0;
                    nxt_lap_reg   = '0;
                end
                LAP:     nxt = RUN;
                default: nxt = cur;
            endcase
        end else if (ev_start) begin
            case (cur)
                RUN, LAP: nxt = PAUSE;
                default:  nxt = RUN;
            endcase
        end else if (ev_lap && (cur == RUN || cur == LAP)) begin
            nxt         = LAP;
            nxt_lap_reg = live_digits;
            if (lap_count < LAP_SAT) begin
                nxt_lap_count = lap_count + 4'd1;
            end
        end
        nxt_running    = (nxt == RUN) || (nxt == LAP);
        nxt_lap_active = (nxt == LAP);
        nxt_disp       = nxt_lap_active ? nxt_lap_reg : live_digits;
    end

    // All outputs are registered and change on the edge that enters a state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur         <= IDLE;
            running     <= 1'b0;
            clear       <= 1'b1;
            disp_digits <= '0;
            lap_active  <= 1'b0;
            lap_count   <= '0;
            lap_reg     <= '0;
        end else begin
            cur         <= nxt;
            running     <= nxt_running;
            clear       <= nxt_clear;
            disp_digits <= nxt_disp;
            lap_active  <= nxt_lap_active;
            lap_count   <= nxt_lap_count;
            lap_reg     <= nxt_lap_reg;
        end
    end

    assign state = cur;
endmodule

// File: tb/tb_cronometro_ctrl.sv
// Randomized bench for cronometro_ctrl against an event-level reference model.

module tb_cronometro_ctrl;
    localparam int D = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_start_n, key_lap_n, key_clear_n;
    logic [31:0] live_digits;
    logic        running, clear, lap_active;
    logic [31:0] disp_digits;
    logic [3:0]  lap_count;
    logic [1:0]  state;

    cronometro_ctrl #(.DEBOUNCE_CYCLES(D), .LAP_MAX(9)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_start_n (key_start_n),
        .key_lap_n   (key_lap_n),
        .key_clear_n (key_clear_n),
        .live_digits (live_digits),
        .running     (running),
        .clear       (clear),
        .disp_digits (disp_digits),
        .lap_active  (lap_active),
        .lap_count   (lap_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit rand_live = 1'b0;

    // Reference model: button events are scheduled on the edge at which the
    // controller acts on them (first low sample edge + 2 + D).
    int          m_state;
    bit          m_run, m_clr, m_lapact;
    int          m_cnt;
    logic [31:0] m_lapreg, m_disp;
    int          ev_s = -1, ev_l = -1, ev_c = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit es, el, ec;
        if (!reset) begin
            m_state = S_IDLE; m_run = 0; m_clr = 1; m_lapact = 0;
            m_cnt = 0; m_lapreg = '0; m_disp = '0;
            ev_s = -1; ev_l = -1; ev_c = -1;
        end else begin
            es = (ev_s == cyc);
            el = (ev_l == cyc);
            ec = (ev_c == cyc);
            m_clr = 0;
            if (ec) begin
                if (m_state == S_IDLE) m_clr = 1;
                else if (m_state == S_PAUSE) begin
                    m_state = S_IDLE; m_clr = 1; m_cnt = 0; m_lapreg = '0;
                end else if (m_state == S_LAP) m_state = S_RUN;
            end else if (es) begin
                m_state = (m_state == S_RUN || m_state == S_LAP) ? S_PAUSE : S_RUN;
            end else if (el && (m_state == S_RUN || m_state == S_LAP)) begin
                m_state = S_LAP;
                m_lapreg = live_digits;
                if (m_cnt < 9) m_cnt++;
            end
            m_run    = (m_state == S_RUN || m_state == S_LAP);
            m_lapact = (m_state == S_LAP);
            m_disp   = m_lapact ? m_lapreg : live_digits;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("running", 32'(running), 32'(m_run));
        chk("clear", 32'(clear), 32'(m_clr));
        chk("lap_active", 32'(lap_active), 32'(m_lapact));
        chk("lap_count", 32'(lap_count), 32'(m_cnt));
        chk("disp_digits", disp_digits, m_disp);
    endtask

    task automatic tick();
        if (rand_live) live_digits = $urandom;
        step();
    endtask

    task automatic gap();
        repeat (D + 3 + $urandom_range(0, 5)) tick();
    endtask

    task automatic press(input bit s, input bit l, input bit c, input int hold);
        int e;
        e = cyc + 3 + D;
        if (s) begin key_start_n = 1'b0; ev_s = e; end
        if (l) begin key_lap_n = 1'b0; ev_l = e; end
        if (c) begin key_clear_n = 1'b0; ev_c = e; end
        repeat (hold) tick();
        key_start_n = 1'b1; key_lap_n = 1'b1; key_clear_n = 1'b1;
        gap();
    endtask

    task automatic glitch(input int which, input int len);
        if (which == 0) key_start_n = 1'b0;
        else if (which == 1) key_lap_n = 1'b0;
        else key_clear_n = 1'b0;
        repeat (len) tick();
        key_start_n = 1'b1; key_lap_n = 1'b1; key_clear_n = 1'b1;
        gap();
    endtask

    initial begin
        int op;
        reset = 1'b0;
        key_start_n = 1'b1; key_lap_n = 1'b1; key_clear_n = 1'b1;
        live_digits = '0;

        repeat (3) step();
        chk("clear_in_reset", 32'(clear), 32'd1);
        reset = 1'b1;
        step();
        chk("clear_after_reset", 32'(clear), 32'd0);
        chk("state_after_reset", 32'(state), 32'd0);

        rand_live = 1'b1;
        press(1, 0, 0, 20);
        chk("start_to_run", 32'(state), 32'(S_RUN));
        chk("running_on", 32'(running), 32'd1);
        glitch(0, 3);
        chk("glitch_ignored", 32'(state), 32'(S_RUN));

        rand_live = 1'b0;
        live_digits = 32'h0012_3456;
        press(0, 1, 0, D + 2);
        chk("lap_capture", disp_digits, 32'h0012_3456);
        live_digits = 32'h0012_3999;
        repeat (3) tick();
        chk("lap_frozen", disp_digits, 32'h0012_3456);
        chk("lap_one", 32'(lap_count), 32'd1);
        press(0, 0, 1, D + 1);
        chk("lap_release", 32'(state), 32'(S_RUN));
        chk("live_again", disp_digits, 32'h0012_3999);

        rand_live = 1'b1;
        repeat (11) press(0, 1, 0, D + $urandom_range(0, 4));
        chk("lap_saturate", 32'(lap_count), 32'd9);
        press(1, 0, 0, D + 2);
        chk("pause", 32'(state), 32'(S_PAUSE));
        chk("pause_stopped", 32'(running), 32'd0);
        press(0, 0, 1, D + 2);
        chk("clear_to_idle", 32'(state), 32'(S_IDLE));
        chk("lap_count_zero", 32'(lap_count), 32'd0);
        press(1, 0, 0, D + 2);
        press(0, 0, 1, D + 2);
        chk("clear_in_run", 32'(state), 32'(S_RUN));
        press(1, 0, 0, D + 2);
        press(1, 0, 1, D + 2);
        chk("clear_beats_start", 32'(state), 32'(S_IDLE));
        press(1, 0, 0, D + 2);
        press(0, 1, 0, D + 2);
        reset = 1'b0;
        tick();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_lap_active", 32'(lap_active), 32'd0);
        chk("reset_disp", disp_digits, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 2) press(1, 0, 0, D + $urandom_range(0, 12));
            else if (op <= 5) press(0, 1, 0, D + $urandom_range(0, 12));
            else if (op <= 7) press(0, 0, 1, D + $urandom_range(0, 12));
            else if (op == 8) glitch($urandom_range(0, 2), $urandom_range(1, D - 1));
            else if (m_state != S_RUN) press(1, 0, 1, D + $urandom_range(0, 6));
            else begin
                key_start_n = 1'b0;
                ev_s = cyc + 3 + D;
                repeat (3) tick();
                reset = 1'b0;
                tick();
                reset = 1'b1;
                key_start_n = 1'b1;
                gap();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
